// File: rtl/touch_filter.sv
// rtl/touch_filter.sv - touch-panel sample conditioner: outlier reject, window average, loss debounce
//
// Ports:
//   clock, reset       system clock, asynchronous active-high reset
//   valid_in           one-cycle strobe qualifying x_in / y_in / touched_in
//   x_in, y_in         raw 12-bit panel coordinates
//   touched_in         panel reports contact
//   x_out, y_out       filtered (window-averaged) position, registered
//   ball_present       tracking flag (high while in TRACK)
//   valid_out          one-cycle pulse when x_out / y_out are refreshed
//   reject_count       saturating count of rejected outliers

module touch_filter #(
   parameter int DEPTH_LOG2   = 2,
   parameter int MAX_JUMP     = 400,
   parameter int LOST_COUNT   = 8,
   parameter int FORCE_ACCEPT = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [11:0] x_in,
   input  logic [11:0] y_in,
   input  logic        touched_in,
   output logic [11:0] x_out,
   output logic [11:0] y_out,
   output logic        ball_present,
   output logic        valid_out,
   output logic [7:0]  reject_count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int SW    = 12 + DEPTH_LOG2;
   localparam int MW    = $clog2(LOST_COUNT + 1);
   localparam int OW    = $clog2(FORCE_ACCEPT + 1);

   typedef enum logic {
      ST_LOST  = 1'b0,
      ST_TRACK = 1'b1
   } state_t;

   state_t state_q, state_d;

   // stage 1: captured sample
   logic        cap_vld_q;
   logic [11:0] cap_x_q, cap_y_q;
   logic        cap_t_q;

   // stage 2: pipeline occupancy and "window changed" flag
   logic        stg2_q;
   logic        emit_q;

   logic [11:0]           buf_x_q [DEPTH];
   logic [11:0]           buf_y_q [DEPTH];
   logic [SW-1:0]         sum_x_q, sum_y_q;
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [MW-1:0]         miss_q, miss_d;
   logic [OW-1:0]         outl_q, outl_d;
   logic [7:0]            reject_q;
   logic [11:0]           x_out_q, y_out_q;
   logic                  valid_out_q;

   logic                  do_preload, do_push, do_reject;
   logic                  outlier;
   logic signed [12:0]    dx, dy;
   logic [12:0]           adx, ady;

   // Outlier distance is measured against the currently published position.
   always_comb begin
      dx      = $signed({1'b0, cap_x_q}) - $signed({1'b0, x_out_q});
      dy      = $signed({1'b0, cap_y_q}) - $signed({1'b0, y_out_q});
      adx     = dx[12] ? $unsigned(-dx) : $unsigned(dx);
      ady     = dy[12] ? $unsigned(-dy) : $unsigned(dy);
      outlier = (adx > 13'(MAX_JUMP)) || (ady > 13'(MAX_JUMP));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_LOST;
         miss_q  <= '0;
         outl_q  <= '0;
      end else begin
         state_q <= state_d;
         miss_q  <= miss_d;
         outl_q  <= outl_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      miss_d     = miss_q;
      outl_d     = outl_q;
      do_preload = 1'b0;
      do_push    = 1'b0;
      do_reject  = 1'b0;
      if (cap_vld_q) begin
         case (state_q)
            ST_LOST: begin
               if (cap_t_q) begin
                  do_preload = 1'b1;
                  state_d    = ST_TRACK;
                  miss_d     = '0;
                  outl_d     = '0;
               end
            end
            ST_TRACK: begin
               if (!cap_t_q) begin
                  outl_d = '0;
                  if (miss_q == MW'(LOST_COUNT - 1)) begin
                     state_d = ST_LOST;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_q + MW'(1);
                  end
               end else begin
                  miss_d = '0;
                  if (outlier) begin
                     // Persistent "outliers" mean the ball really moved: re-acquire.
                     if (outl_q == OW'(FORCE_ACCEPT - 1)) begin
                        do_preload = 1'b1;
                        outl_d     = '0;
                     end else begin
                        do_reject = 1'b1;
                        outl_d    = outl_q + OW'(1);
                     end
                  end else begin
                     do_push = 1'b1;
                     outl_d  = '0;
                  end
               end
            end
            default: state_d = ST_LOST;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cap_vld_q   <= 1'b0;
         cap_x_q     <= '0;
         cap_y_q     <= '0;
         cap_t_q     <= 1'b0;
         stg2_q      <= 1'b0;
         emit_q      <= 1'b0;
         sum_x_q     <= '0;
         sum_y_q     <= '0;
         wr_ptr_q    <= '0;
         reject_q    <= '0;
         x_out_q     <= 12'd2048;
         y_out_q     <= 12'd2048;
         valid_out_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_x_q[i] <= '0;
            buf_y_q[i] <= '0;
         end
      end else begin
         // Only one sample in flight: strobes during stages 1/2 are dropped.
         cap_vld_q <= valid_in && !cap_vld_q && !stg2_q;
         if (valid_in && !cap_vld_q && !stg2_q) begin
            cap_x_q <= x_in;
            cap_y_q <= y_in;
            cap_t_q <= touched_in;
         end

         stg2_q <= cap_vld_q;
         emit_q <= do_preload || do_push;

         if (do_preload) begin
            for (int i = 0; i < DEPTH; i++) begin
               buf_x_q[i] <= cap_x_q;
               buf_y_q[i] <= cap_y_q;
            end
            sum_x_q  <= {cap_x_q, {DEPTH_LOG2{1'b0}}};
            sum_y_q  <= {cap_y_q, {DEPTH_LOG2{1'b0}}};
            wr_ptr_q <= '0;
         end else if (do_push) begin
            buf_x_q[wr_ptr_q] <= cap_x_q;
            buf_y_q[wr_ptr_q] <= cap_y_q;
            sum_x_q  <= sum_x_q + SW'(cap_x_q) - SW'(buf_x_q[wr_ptr_q]);
            sum_y_q  <= sum_y_q + SW'(cap_y_q) - SW'(buf_y_q[wr_ptr_q]);
            wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
         end

         if (do_reject && (reject_q != 8'hFF)) begin
            reject_q <= reject_q + 8'd1;
         end

         valid_out_q <= emit_q;
         if (emit_q) begin
            x_out_q <= sum_x_q[SW-1 -: 12];
            y_out_q <= sum_y_q[SW-1 -: 12];
         end
      end
   end

   assign x_out        = x_out_q;
   assign y_out        = y_out_q;
   assign ball_present = (state_q == ST_TRACK);
   assign valid_out    = valid_out_q;
   assign reject_count = reject_q;

endmodule

// File: tb/tb_touch_filter.sv
// tb/tb_touch_filter.sv - self-checking bench for touch_filter

module tb_touch_filter;

   logic        clock;
   logic        reset;
   logic        valid_in;
   logic [11:0] x_in, y_in;
   logic        touched_in;
   logic [11:0] x_out, y_out;
   logic        ball_present;
   logic        valid_out;
   logic [7:0]  reject_count;

   touch_filter dut (
      .clock        (clock),
      .reset        (reset),
      .valid_in     (valid_in),
      .x_in         (x_in),
      .y_in         (y_in),
      .touched_in   (touched_in),
      .x_out        (x_out),
      .y_out        (y_out),
      .ball_present (ball_present),
      .valid_out    (valid_out),
      .reject_count (reject_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 0;

   // Reference model: sample-level rules, window kept as a queue of samples.
   int m_wx[$];
   int m_wy[$];
   bit m_present;
   int m_miss, m_outl, m_rej, m_x, m_y;
   int exp_pulse  = -1;
   int exp_settle = 0;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_reset();
      m_wx.delete();
      m_wy.delete();
      m_present = 0;
      m_miss = 0;
      m_outl = 0;
      m_rej = 0;
      m_x = 2048;
      m_y = 2048;
   endtask

   task automatic model_avg();
      int sx, sy;
      sx = 0;
      sy = 0;
      foreach (m_wx[i]) sx += m_wx[i];
      foreach (m_wy[i]) sy += m_wy[i];
      m_x = sx / 4;
      m_y = sy / 4;
   endtask

   task automatic model_preload(input int x, input int y);
      m_wx = {x, x, x, x};
      m_wy = {y, y, y, y};
      m_present = 1;
      m_miss = 0;
      m_outl = 0;
      model_avg();
   endtask

   task automatic model_sample(input bit t, input int x, input int y, output bit emit);
      emit = 0;
      if (!m_present) begin
         if (t) begin
            model_preload(x, y);
            emit = 1;
         end
      end else if (!t) begin
         m_outl = 0;
         m_miss++;
         if (m_miss == 8) begin
            m_present = 0;
            m_miss = 0;
         end
      end else begin
         m_miss = 0;
         if (iabs(x - m_x) > 400 || iabs(y - m_y) > 400) begin
            m_outl++;
            if (m_outl == 3) begin
               model_preload(x, y);
               emit = 1;
            end else if (m_rej < 255) begin
               m_rej++;
            end
         end else begin
            m_outl = 0;
            m_wx.push_back(x);
            m_wy.push_back(y);
            void'(m_wx.pop_front());
            void'(m_wy.pop_front());
            model_avg();
            emit = 1;
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         chk("valid_out", int'(valid_out), (cyc == exp_pulse) ? 1 : 0);
         if (cyc >= exp_settle) begin
            chk("x_out", int'(x_out), m_x);
            chk("y_out", int'(y_out), m_y);
            chk("ball_present", int'(ball_present), int'(m_present));
            chk("reject_count", int'(reject_count), m_rej);
         end
      end
   end

   // Called at posedge+1; drives a one-cycle strobe.
   task automatic send(input bit t, input int x, input int y, input bit mdl);
      bit e;
      valid_in   = 1'b1;
      touched_in = t;
      x_in       = 12'(x);
      y_in       = 12'(y);
      if (mdl) begin
         model_sample(t, x, y, e);
         exp_settle = cyc + 3;
         exp_pulse  = e ? cyc + 3 : -1;
      end
      @(posedge clock);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      model_reset();
      exp_settle = cyc;
      exp_pulse  = -1;
      repeat (n) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      valid_in   = 1'b0;
      touched_in = 1'b0;
      x_in       = '0;
      y_in       = '0;
      model_reset();

      // 1: reset for 3 cycles, then untouched samples are ignored
      repeat (2) @(posedge clock);
      #1;
      chk_en = 1;
      idle(1);
      reset = 1'b0;
      chk("rst_x", int'(x_out), 2048);
      chk("rst_y", int'(y_out), 2048);
      chk("rst_bp", int'(ball_present), 0);
      chk("rst_rej", int'(reject_count), 0);
      send(0, 100, 100, 1); idle(5);
      send(0, 500, 900, 1); idle(5);

      // 2: acquire from LOST
      send(1, 1000, 3000, 1); idle(6);
      chk("acq_x", int'(x_out), 1000);
      chk("acq_y", int'(y_out), 3000);
      chk("acq_bp", int'(ball_present), 1);

      // 3: window averaging, plus strobes at n+1 and n+2 that must be dropped
      send(1, 1004, 3000, 1);
      send(1, 4000, 4000, 0);
      send(1, 4000, 10, 0);
      idle(7);
      chk("avg1_x", int'(x_out), 1001);
      send(1, 1008, 3000, 1); idle(9);
      chk("avg2_x", int'(x_out), 1003);
      send(1, 1012, 3000, 1); idle(9);
      chk("avg3_x", int'(x_out), 1006);
      chk("avg3_y", int'(y_out), 3000);

      // 4: jump boundary and forced re-acquire
      do_reset(2);
      send(1, 1000, 3000, 1); idle(5);
      send(1, 1400, 3000, 1); idle(5);
      chk("jump400_x", int'(x_out), 1100);
      do_reset(2);
      send(1, 1000, 3000, 1); idle(5);
      send(1, 1401, 3000, 1); idle(5);
      chk("jump401_rej", int'(reject_count), 1);
      chk("jump401_x", int'(x_out), 1000);
      send(1, 1401, 3000, 1); idle(5);
      chk("out2_rej", int'(reject_count), 2);
      send(1, 1401, 3000, 1); idle(5);
      chk("force_x", int'(x_out), 1401);
      chk("force_rej", int'(reject_count), 2);

      // 5: dropout debounce
      for (int i = 0; i < 7; i++) begin
         send(0, 0, 0, 1); idle(4);
      end
      chk("miss7_bp", int'(ball_present), 1);
      send(1, 1401, 3000, 1); idle(4);
      for (int i = 0; i < 7; i++) begin
         send(0, 0, 0, 1); idle(4);
      end
      chk("miss7b_bp", int'(ball_present), 1);
      send(0, 0, 0, 1); idle(4);
      chk("miss8_bp", int'(ball_present), 0);
      chk("miss8_x", int'(x_out), 1401);
      chk("miss8_y", int'(y_out), 3000);
      send(1, 2000, 2000, 1); idle(5);
      chk("reacq_x", int'(x_out), 2000);
      chk("reacq_bp", int'(ball_present), 1);

      // 6: reset with a sample in flight, then reject saturation
      send(1, 2010, 2000, 1);
      do_reset(3);
      idle(5);
      chk("midrst_x", int'(x_out), 2048);
      chk("midrst_bp", int'(ball_present), 0);
      send(1, 1000, 1000, 1); idle(4);
      for (int i = 0; i < 300; i++) begin
         send(1, 3000, 1000, 1); idle(4);
         send(0, 0, 0, 1); idle(4);
      end
      chk("sat_rej", int'(reject_count), 255);
      chk("sat_x", int'(x_out), 1000);
      chk("sat_bp", int'(ball_present), 1);

      idle(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
